// File: rtl/fm_wb_packer.sv
// Write-back packer for one PE row: packs 8-bit pixels and 6-bit guards into SRAM words.
// Optional feature macro: FM_WB_ZERO_CNT_EN adds zero_cnt_o, a count of accepted 0x00 pixels.

module fm_wb_lane_packer #(
    parameter int LANE_W = 8,
    parameter int LANES  = 8,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic [ADDR_W-1:0]       base_addr_i,
    input  logic                    pack_en_i,
    input  logic                    flush_en_i,
    input  logic [LANE_W-1:0]       in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [ADDR_W-1:0]       out_addr_o,
    output logic [LANE_W*LANES-1:0] out_data_o,
    output logic [LANES-1:0]        out_mask_o,
    output logic                    empty_o
);

    localparam int               CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LANES - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LANE_W*LANES-1:0] pack_q, pack_d;
    logic [LANE_W*LANES-1:0] data_q, data_d;
    logic [LANES-1:0]        mask_q, mask_d;
    logic                    valid_q, valid_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [LANE_W*LANES-1:0] merged;
    logic                    accept;
    logic                    hs;
    logic                    out_free;

    // The last lane may only be taken when the output register can take the word.
    assign in_ready_o = pack_en_i && !(cnt_q == LAST && valid_q && !out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign hs         = valid_q && out_ready_i;
    assign out_free   = !valid_q || out_ready_i;

    always_comb begin
        cnt_d   = cnt_q;
        pack_d  = pack_q;
        data_d  = data_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        merged  = pack_q;
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) == cnt_q) begin
                merged[i*LANE_W +: LANE_W] = in_data_i;
            end
        end

        if (hs) begin
            valid_d = 1'b0;
            addr_d  = addr_q + ADDR_W'(1);
        end

        if (clear_i) begin
            cnt_d  = '0;
            pack_d = '0;
            addr_d = base_addr_i;
        end else if (accept) begin
            if (cnt_q == LAST) begin
                data_d  = merged;
                mask_d  = '1;
                valid_d = 1'b1;
                pack_d  = '0;
                cnt_d   = '0;
            end else begin
                pack_d = merged;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else if (flush_en_i && cnt_q != '0 && out_free) begin
            // Unused lanes are already zero because pack_q is cleared on every hand-off.
            data_d = pack_q;
            for (int i = 0; i < LANES; i++) begin
                mask_d[i] = (CNT_W'(i) < cnt_q);
            end
            valid_d = 1'b1;
            pack_d  = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pack_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_addr_o  = addr_q;
    assign out_data_o  = data_q;
    assign out_mask_o  = mask_q;
    assign empty_o     = (cnt_q == '0) && !valid_q;

endmodule

// state | meaning
// IDLE  | waiting for start_i; addresses latched on start
// PACK  | accepting pixels and guards, full words written out
// FLUSH | inputs closed; partial words written, waiting for both paths to drain
// DONE  | one-cycle done_o pulse, then back to IDLE
module fm_wb_packer #(
    parameter int WORD_BYTES     = 8,
    parameter int GUARD_PER_WORD = 4,
    parameter int ADDR_W         = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [ADDR_W-1:0]           base_addr_i,
    input  logic [ADDR_W-1:0]           guard_base_addr_i,
    input  logic [7:0]                  data_i,
    input  logic                        data_valid_i,
    output logic                        data_ready_o,
    input  logic [5:0]                  guard_i,
    input  logic                        guard_valid_i,
    output logic                        guard_ready_o,
    input  logic                        finish_i,
    output logic                        mem_wr_valid_o,
    input  logic                        mem_wr_ready_i,
    output logic [ADDR_W-1:0]           mem_wr_addr_o,
    output logic [8*WORD_BYTES-1:0]     mem_wr_data_o,
    output logic [WORD_BYTES-1:0]       mem_wr_mask_o,
    output logic                        gmem_wr_valid_o,
    input  logic                        gmem_wr_ready_i,
    output logic [ADDR_W-1:0]           gmem_wr_addr_o,
    output logic [6*GUARD_PER_WORD-1:0] gmem_wr_data_o,
    output logic [GUARD_PER_WORD-1:0]   gmem_wr_mask_o,
`ifdef FM_WB_ZERO_CNT_EN
    output logic [15:0]                 zero_cnt_o,
`endif
    output logic                        busy_o,
    output logic                        done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   start_acc;
    logic   pack_en;
    logic   flush_en;
    logic   fm_empty;
    logic   g_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i)             state_d = S_PACK;
            S_PACK:  if (finish_i)            state_d = S_FLUSH;
            S_FLUSH: if (fm_empty && g_empty) state_d = S_DONE;
            S_DONE:                           state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_acc = (state_q == S_IDLE) && start_i;
        pack_en   = (state_q == S_PACK);
        flush_en  = (state_q == S_FLUSH);
        busy_o    = (state_q != S_IDLE);
        done_o    = (state_q == S_DONE);
    end

    fm_wb_lane_packer #(
        .LANE_W (8),
        .LANES  (WORD_BYTES),
        .ADDR_W (ADDR_W)
    ) u_fm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (start_acc),
        .base_addr_i (base_addr_i),
        .pack_en_i   (pack_en),
        .flush_en_i  (flush_en),
        .in_data_i   (data_i),
        .in_valid_i  (data_valid_i),
        .in_ready_o  (data_ready_o),
        .out_valid_o (mem_wr_valid_o),
        .out_ready_i (mem_wr_ready_i),
        .out_addr_o  (mem_wr_addr_o),
        .out_data_o  (mem_wr_data_o),
        .out_mask_o  (mem_wr_mask_o),
        .empty_o     (fm_empty)
    );

    fm_wb_lane_packer #(
        .LANE_W (6),
        .LANES  (GUARD_PER_WORD),
        .ADDR_W (ADDR_W)
    ) u_guard (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (start_acc),
        .base_addr_i (guard_base_addr_i),
        .pack_en_i   (pack_en),
        .flush_en_i  (flush_en),
        .in_data_i   (guard_i),
        .in_valid_i  (guard_valid_i),
        .in_ready_o  (guard_ready_o),
        .out_valid_o (gmem_wr_valid_o),
        .out_ready_i (gmem_wr_ready_i),
        .out_addr_o  (gmem_wr_addr_o),
        .out_data_o  (gmem_wr_data_o),
        .out_mask_o  (gmem_wr_mask_o),
        .empty_o     (g_empty)
    );

`ifdef FM_WB_ZERO_CNT_EN
    logic [15:0] zero_cnt_q, zero_cnt_d;

    always_comb begin
        zero_cnt_d = zero_cnt_q;
        if (start_acc) begin
            zero_cnt_d = '0;
        end else if (data_valid_i && data_ready_o && data_i == 8'h00 && zero_cnt_q != 16'hFFFF) begin
            zero_cnt_d = zero_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt_q <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign zero_cnt_o = zero_cnt_q;
`endif

endmodule

// File: tb/tb_fm_wb_packer.sv
// Self-checking bench for fm_wb_packer: directed scenarios plus randomized streams
// compared against a word-chunking reference model.

module tb_fm_wb_packer;

    localparam int WB = 8;
    localparam int GP = 4;
    localparam int AW = 10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_i;
    logic [AW-1:0]  base_addr_i, guard_base_addr_i;
    logic [7:0]     data_i;
    logic           data_valid_i, data_ready_o;
    logic [5:0]     guard_i;
    logic           guard_valid_i, guard_ready_o;
    logic           finish_i;
    logic           mem_wr_valid_o, mem_wr_ready_i;
    logic [AW-1:0]  mem_wr_addr_o;
    logic [8*WB-1:0] mem_wr_data_o;
    logic [WB-1:0]  mem_wr_mask_o;
    logic           gmem_wr_valid_o, gmem_wr_ready_i;
    logic [AW-1:0]  gmem_wr_addr_o;
    logic [6*GP-1:0] gmem_wr_data_o;
    logic [GP-1:0]  gmem_wr_mask_o;
    logic           busy_o, done_o;
`ifdef FM_WB_ZERO_CNT_EN
    logic [15:0]    zero_cnt_o;
`endif

    fm_wb_packer #(.WORD_BYTES(WB), .GUARD_PER_WORD(GP), .ADDR_W(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_i           (start_i),
        .base_addr_i       (base_addr_i),
        .guard_base_addr_i (guard_base_addr_i),
        .data_i            (data_i),
        .data_valid_i      (data_valid_i),
        .data_ready_o      (data_ready_o),
        .guard_i           (guard_i),
        .guard_valid_i     (guard_valid_i),
        .guard_ready_o     (guard_ready_o),
        .finish_i          (finish_i),
        .mem_wr_valid_o    (mem_wr_valid_o),
        .mem_wr_ready_i    (mem_wr_ready_i),
        .mem_wr_addr_o     (mem_wr_addr_o),
        .mem_wr_data_o     (mem_wr_data_o),
        .mem_wr_mask_o     (mem_wr_mask_o),
        .gmem_wr_valid_o   (gmem_wr_valid_o),
        .gmem_wr_ready_i   (gmem_wr_ready_i),
        .gmem_wr_addr_o    (gmem_wr_addr_o),
        .gmem_wr_data_o    (gmem_wr_data_o),
        .gmem_wr_mask_o    (gmem_wr_mask_o),
`ifdef FM_WB_ZERO_CNT_EN
        .zero_cnt_o        (zero_cnt_o),
`endif
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [125:0] all_out;
    assign all_out = {busy_o, done_o, data_ready_o, guard_ready_o, mem_wr_valid_o, gmem_wr_valid_o,
                      mem_wr_addr_o, gmem_wr_addr_o, mem_wr_data_o, gmem_wr_data_o,
                      mem_wr_mask_o, gmem_wr_mask_o};

    // stimulus streams for the next job
    logic [7:0]      pix_q[$];
    logic [5:0]      grd_q[$];
    // writes captured during the last job
    logic [AW-1:0]   fa_q[$];
    logic [8*WB-1:0] fd_q[$];
    logic [WB-1:0]   fm_q[$];
    logic [AW-1:0]   ga_q[$];
    logic [6*GP-1:0] gd_q[$];
    logic [GP-1:0]   gm_q[$];
    int              stall_seen;

    task automatic drive_idle();
        start_i = 1'b0; finish_i = 1'b0;
        data_valid_i = 1'b0; guard_valid_i = 1'b0;
        data_i = '0; guard_i = '0;
        mem_wr_ready_i = 1'b1; gmem_wr_ready_i = 1'b1;
    endtask

    // Runs one start..done job and compares every write against the chunking model.
    // rdy_mode: 0 ready tied high, 1 random ready, 2 fm ready held low for 10 pending cycles.
    task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] gbase, input int rdy_mode,
                           input bit rnd_valid, input bit fin_with_last, input bit spurious);
        logic [AW-1:0]   ex_fa[$], ex_ga[$];
        logic [8*WB-1:0] ex_fd[$];
        logic [WB-1:0]   ex_fm[$];
        logic [6*GP-1:0] ex_gd[$];
        logic [GP-1:0]   ex_gm[$];
        logic [8*WB-1:0] ed;  logic [WB-1:0] em;
        logic [6*GP-1:0] egd; logic [GP-1:0] egm;
        logic [8*WB-1:0] prev_d; logic [AW-1:0] prev_a; logic [WB-1:0] prev_m;
        bit prev_stall, fin_sent, done_seen;
        int n, ng, pi, gi, cyc, post, stall_left, last_hs, done_cyc, done_cnt, late_wr, zeros;

        n = pix_q.size(); ng = grd_q.size();
        zeros = 0;
        foreach (pix_q[i]) if (pix_q[i] == 8'h00) zeros++;
        for (int k = 0; k * WB < n; k++) begin
            ed = '0; em = '0;
            for (int b = 0; b < WB; b++)
                if (k * WB + b < n) begin ed[b*8 +: 8] = pix_q[k*WB+b]; em[b] = 1'b1; end
            ex_fa.push_back(base + AW'(k)); ex_fd.push_back(ed); ex_fm.push_back(em);
        end
        for (int k = 0; k * GP < ng; k++) begin
            egd = '0; egm = '0;
            for (int b = 0; b < GP; b++)
                if (k * GP + b < ng) begin egd[b*6 +: 6] = grd_q[k*GP+b]; egm[b] = 1'b1; end
            ex_ga.push_back(gbase + AW'(k)); ex_gd.push_back(egd); ex_gm.push_back(egm);
        end
        fa_q.delete(); fd_q.delete(); fm_q.delete(); ga_q.delete(); gd_q.delete(); gm_q.delete();
        stall_seen = 0;

        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = base; guard_base_addr_i = gbase;
        @(posedge clk); #1;
        start_i = 1'b0; base_addr_i = AW'($urandom); guard_base_addr_i = AW'($urandom);

        pi = 0; gi = 0; cyc = 0; post = 0; last_hs = -1; done_cyc = 0; done_cnt = 0; late_wr = 0;
        fin_sent = 0; done_seen = 0; prev_stall = 0;
        prev_d = '0; prev_a = '0; prev_m = '0;
        stall_left = (rdy_mode == 2) ? 10 : 0;
        while (post < 6 && cyc < 3000) begin
            data_valid_i  = (pi < n) && (!rnd_valid || $urandom_range(0, 2) != 0);
            data_i        = (pi < n) ? pix_q[pi] : 8'($urandom);
            guard_valid_i = (gi < ng) && (!rnd_valid || $urandom_range(0, 2) != 0);
            guard_i       = (gi < ng) ? grd_q[gi] : 6'($urandom);
            finish_i = 1'b0;
            if (!fin_sent) begin
                if (fin_with_last && pi == n - 1 && gi == ng) begin
                    data_valid_i = 1'b1; finish_i = 1'b1; fin_sent = 1;
                end else if (!fin_with_last && pi == n && gi == ng) begin
                    finish_i = 1'b1; fin_sent = 1;
                end
            end
            start_i = spurious && !fin_sent && pi > 0 && $urandom_range(0, 7) == 0;
            case (rdy_mode)
                1:       begin mem_wr_ready_i = ($urandom_range(0, 3) != 0); gmem_wr_ready_i = ($urandom_range(0, 3) != 0); end
                2:       begin mem_wr_ready_i = (stall_left == 0); gmem_wr_ready_i = 1'b1; end
                default: begin mem_wr_ready_i = 1'b1; gmem_wr_ready_i = 1'b1; end
            endcase

            @(negedge clk);
            if (rdy_mode == 2 && data_valid_i && !data_ready_o && !fin_sent) stall_seen++;
            if (data_valid_i && data_ready_o) pi++;
            if (guard_valid_i && guard_ready_o) gi++;

            if (mem_wr_valid_o && !mem_wr_ready_i) begin
                if (prev_stall) begin
                    checks++;
                    if ({mem_wr_data_o, mem_wr_addr_o, mem_wr_mask_o} !== {prev_d, prev_a, prev_m}) begin
                        errors++;
                        $display("FAIL stall_hold: data=%h addr=%h mask=%h, required data=%h addr=%h mask=%h",
                                 mem_wr_data_o, mem_wr_addr_o, mem_wr_mask_o, prev_d, prev_a, prev_m);
                    end
                end
                prev_stall = 1; prev_d = mem_wr_data_o; prev_a = mem_wr_addr_o; prev_m = mem_wr_mask_o;
                if (stall_left > 0) stall_left--;
            end else begin
                prev_stall = 0;
            end

            if (mem_wr_valid_o && mem_wr_ready_i) begin
                fa_q.push_back(mem_wr_addr_o); fd_q.push_back(mem_wr_data_o); fm_q.push_back(mem_wr_mask_o);
                last_hs = cyc;
                if (done_seen) late_wr++;
                checks++;
                if (ex_fa.size() == 0) begin
                    errors++;
                    $display("FAIL fm_write: unexpected write addr=%h data=%h mask=%h", mem_wr_addr_o, mem_wr_data_o, mem_wr_mask_o);
                end else begin
                    if ({mem_wr_addr_o, mem_wr_data_o, mem_wr_mask_o} !== {ex_fa[0], ex_fd[0], ex_fm[0]}) begin
                        errors++;
                        $display("FAIL fm_write: addr=%h data=%h mask=%h, required addr=%h data=%h mask=%h",
                                 mem_wr_addr_o, mem_wr_data_o, mem_wr_mask_o, ex_fa[0], ex_fd[0], ex_fm[0]);
                    end
                    void'(ex_fa.pop_front()); void'(ex_fd.pop_front()); void'(ex_fm.pop_front());
                end
            end
            if (gmem_wr_valid_o && gmem_wr_ready_i) begin
                ga_q.push_back(gmem_wr_addr_o); gd_q.push_back(gmem_wr_data_o); gm_q.push_back(gmem_wr_mask_o);
                last_hs = cyc;
                if (done_seen) late_wr++;
                checks++;
                if (ex_ga.size() == 0) begin
                    errors++;
                    $display("FAIL guard_write: unexpected write addr=%h data=%h mask=%h", gmem_wr_addr_o, gmem_wr_data_o, gmem_wr_mask_o);
                end else begin
                    if ({gmem_wr_addr_o, gmem_wr_data_o, gmem_wr_mask_o} !== {ex_ga[0], ex_gd[0], ex_gm[0]}) begin
                        errors++;
                        $display("FAIL guard_write: addr=%h data=%h mask=%h, required addr=%h data=%h mask=%h",
                                 gmem_wr_addr_o, gmem_wr_data_o, gmem_wr_mask_o, ex_ga[0], ex_gd[0], ex_gm[0]);
                    end
                    void'(ex_ga.pop_front()); void'(ex_gd.pop_front()); void'(ex_gm.pop_front());
                end
            end

            if (done_o) begin
                done_cnt++;
                if (!done_seen) done_cyc = cyc;
                done_seen = 1;
            end
            if (done_seen) post++;
            cyc++;
            @(posedge clk); #1;
        end
        drive_idle();

        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL done_timeout: no done_o within %0d cycles (pixels sent %0d/%0d, guards %0d/%0d)", cyc, pi, n, gi, ng);
        end
        checks++;
        if (ex_fa.size() + ex_ga.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: %0d fm and %0d guard words never written, required 0", ex_fa.size(), ex_ga.size());
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL done_pulse: done_o high for %0d cycles, required 1", done_cnt);
        end
        checks++;
        if (done_seen && !(done_cyc > last_hs && done_cyc - last_hs <= 3)) begin
            errors++;
            $display("FAIL done_timing: done_o at cycle %0d, last write handshake at %0d, required 1..3 cycles after", done_cyc, last_hs);
        end
        checks++;
        if (late_wr != 0) begin
            errors++;
            $display("FAIL write_after_done: %0d writes after done_o, required 0", late_wr);
        end
`ifdef FM_WB_ZERO_CNT_EN
        checks++;
        if (zero_cnt_o !== 16'(zeros)) begin
            errors++;
            $display("FAIL zero_cnt: got %0d, required %0d", zero_cnt_o, zeros);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        base_addr_i = '0; guard_base_addr_i = '0;
        #3;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required all zero", all_out);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h, required all zero", all_out);
        end
    endtask

    task automatic test_finish_idle();
        @(posedge clk); #1;
        finish_i = 1'b1;
        @(posedge clk); #1;
        finish_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy_o, done_o, mem_wr_valid_o, gmem_wr_valid_o} !== 4'b0000) begin
                errors++;
                $display("FAIL finish_in_idle: busy/done/wr/gwr=%b, required 0000", {busy_o, done_o, mem_wr_valid_o, gmem_wr_valid_o});
            end
        end
    endtask

    task automatic test_basic_pack();
        pix_q.delete(); grd_q.delete();
        for (int i = 1; i <= 16; i++) pix_q.push_back(8'(i));
        run_job(10'h010, 10'h100, 0, 0, 0, 0);
        checks++;
        if (fd_q.size() != 2 || fa_q[0] !== 10'h010 || fd_q[0] !== 64'h0807060504030201 || fm_q[0] !== 8'hFF) begin
            errors++;
            $display("FAIL basic_word0: n=%0d addr=%h data=%h mask=%h, required 2 words, 010/0807060504030201/ff",
                     fd_q.size(), fa_q[0], fd_q[0], fm_q[0]);
        end
        checks++;
        if (fa_q[1] !== 10'h011 || fd_q[1] !== 64'h100F0E0D0C0B0A09 || fm_q[1] !== 8'hFF) begin
            errors++;
            $display("FAIL basic_word1: addr=%h data=%h mask=%h, required 011/100f0e0d0c0b0a09/ff", fa_q[1], fd_q[1], fm_q[1]);
        end
    endtask

    task automatic test_partial_flush();
        pix_q.delete(); grd_q.delete();
        pix_q.push_back(8'hAA); pix_q.push_back(8'hBB); pix_q.push_back(8'hCC);
        for (int i = 0; i < 5; i++) grd_q.push_back(6'($urandom));
        run_job(10'h040, 10'h080, 0, 0, 0, 0);
        checks++;
        if (fd_q.size() != 1 || fd_q[0] !== 64'h0000000000CCBBAA || fm_q[0] !== 8'h07) begin
            errors++;
            $display("FAIL partial_fm: n=%0d data=%h mask=%h, required 1 word 0000000000ccbbaa/07", fd_q.size(), fd_q[0], fm_q[0]);
        end
        checks++;
        if (gm_q.size() != 2 || gm_q[0] !== 4'hF || gm_q[1] !== 4'h1 || ga_q[1] !== 10'h081) begin
            errors++;
            $display("FAIL partial_guard: n=%0d masks=%h,%h addr1=%h, required 2 words f,1 addr1=081",
                     gm_q.size(), gm_q[0], gm_q[1], ga_q[1]);
        end
    endtask

    task automatic test_backpressure();
        pix_q.delete(); grd_q.delete();
        for (int i = 0; i < 16; i++) pix_q.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) grd_q.push_back(6'($urandom));
        run_job(10'h123, 10'h200, 2, 0, 0, 0);
        checks++;
        if (stall_seen == 0) begin
            errors++;
            $display("FAIL backpressure_ready: data_ready_o never dropped while the word was stalled, required a drop");
        end
    endtask

    task automatic test_wrap();
        pix_q.delete(); grd_q.delete();
        for (int i = 0; i < 16; i++) pix_q.push_back(8'($urandom));
        for (int i = 0; i < 8; i++) grd_q.push_back(6'($urandom));
        run_job(10'h3FF, 10'h3FF, 0, 0, 0, 0);
        checks++;
        if (fa_q.size() != 2 || fa_q[0] !== 10'h3FF || fa_q[1] !== 10'h000) begin
            errors++;
            $display("FAIL wrap_addr: n=%0d addrs=%h,%h, required 3ff,000", fa_q.size(), fa_q[0], fa_q[1]);
        end
        checks++;
        if (ga_q.size() != 2 || ga_q[1] !== 10'h000) begin
            errors++;
            $display("FAIL wrap_guard_addr: n=%0d addr1=%h, required 000", ga_q.size(), ga_q[1]);
        end
    endtask

    task automatic test_last_with_finish();
        pix_q.delete(); grd_q.delete();
        for (int i = 0; i < 8; i++) pix_q.push_back(8'($urandom));
        run_job(10'h055, 10'h000, 0, 0, 1, 0);
        checks++;
        if (fd_q.size() != 1 || fm_q[0] !== 8'hFF) begin
            errors++;
            $display("FAIL last_with_finish: %0d writes mask0=%h, required 1 write mask ff", fd_q.size(), fm_q[0]);
        end
    endtask

    task automatic test_reset_mid_pack();
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = 10'h020; guard_base_addr_i = 10'h030;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_valid_i = 1'b1; data_i = 8'($urandom);
            guard_valid_i = (i < 2); guard_i = 6'($urandom);
            @(posedge clk); #1;
        end
        drive_idle();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_pack: outputs %h, required all zero", all_out);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_wr_valid_o, gmem_wr_valid_o, busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold: wr/gwr/busy=%b, required 000", {mem_wr_valid_o, gmem_wr_valid_o, busy_o});
        end
        rst_n = 1'b1;
        pix_q.delete(); grd_q.delete();
        for (int i = 0; i < 11; i++) pix_q.push_back(8'($urandom));
        for (int i = 0; i < 3; i++) grd_q.push_back(6'($urandom));
        run_job(10'h020, 10'h030, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int n, ng;
        for (int it = 0; it < 6; it++) begin
            pix_q.delete(); grd_q.delete();
            n  = $urandom_range(1, 40);
            ng = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) pix_q.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
            for (int i = 0; i < ng; i++) grd_q.push_back(6'($urandom));
            run_job(AW'($urandom), AW'($urandom), 1, 1, 0, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_finish_idle();
        test_basic_pack();
        test_partial_flush();
        test_backpressure();
        test_wrap();
        test_last_with_finish();
        test_reset_mid_pack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fm_wb_packer.md
Name: fm_wb_packer

Overview:
- One instance per PE row, directly downstream of the PE matrix write-back outputs (write_back_data_o, guard_o and their valid and finish signals).
- Packs the 8-bit output-pixel stream into WORD_BYTES-wide feature-map SRAM words.
- Packs the 6-bit guard stream into GUARD_PER_WORD-wide guard SRAM words.
- Generates incrementing write addresses, flushes partial words on the row-finish pulse, then signals completion.

Parameters:
WORD_BYTES, 8, bytes per feature-map SRAM word (power of 2, 2..16)
GUARD_PER_WORD, 4, 6-bit guard entries per guard SRAM word (power of 2, 2..8)
ADDR_W, 10, address width for both SRAM ports

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  start pulse; accepted in IDLE only
base_addr_i  in  ADDR_W  first feature-map word address, latched on start
guard_base_addr_i  in  ADDR_W  first guard word address, latched on start
data_i  in  8  output pixel (from write_back_data_o)
data_valid_i  in  1  pixel valid
data_ready_o  out  1  pixel accepted when valid&ready (drives fm_buf_ready)
guard_i  in  6  guard entry (from guard_o)
guard_valid_i  in  1  guard valid
guard_ready_o  out  1  guard accepted (drives guard_buf_ready)
finish_i  in  1  end-of-stream pulse (from write_back_finish)
mem_wr_valid_o  out  1  feature-map word write request
mem_wr_ready_i  in  1  SRAM accepts write
mem_wr_addr_o  out  ADDR_W  write address
mem_wr_data_o  out  8*WORD_BYTES  packed word, byte 0 in LSBs
mem_wr_mask_o  out  WORD_BYTES  byte enables
gmem_wr_valid_o  out  1  guard word write request
gmem_wr_ready_i  in  1  guard SRAM accepts
gmem_wr_addr_o  out  ADDR_W  guard address
gmem_wr_data_o  out  6*GUARD_PER_WORD  packed guard word, entry 0 in LSBs
gmem_wr_mask_o  out  GUARD_PER_WORD  entry enables
busy_o  out  1  high when state is not IDLE
done_o  out  1  one-cycle pulse after the final write handshake

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; lane counters, address counters and pack registers cleared.
- FSM states and transitions:
  - IDLE: start_i -> PACK; latch both base addresses into the address counters; clear lane counters.
  - PACK: finish_i -> FLUSH.
  - FLUSH: when both pack registers are empty and both output registers are empty (valid=0) -> DONE.
  - DONE: done_o=1 for exactly one cycle -> IDLE.
- Ignored events: finish_i outside PACK; start_i outside IDLE.
- Pixel path, PACK only:
  - data_ready_o = PACK && !(byte_cnt==WORD_BYTES-1 && mem_wr_valid_o && !mem_wr_ready_i).
  - Accepted byte is written to lane byte_cnt; byte_cnt increments.
  - On accepting lane WORD_BYTES-1: word moves to the output register, with mem_wr_valid_o=1 the next cycle (latency 1), mask all ones; byte_cnt wraps to 0.
  - Output register holds data/addr/mask stable until mem_wr_ready_i.
  - On handshake: address counter increments, wrapping modulo 2^ADDR_W.
- Guard path: identical rules, using guard_cnt, GUARD_PER_WORD, the gmem_* ports and its own address counter. The two paths are independent; no ordering between them.
- finish_i coincident with an accepted byte/guard: the item is packed first; FLUSH sees the updated count.
- FLUSH, per path:
  - If count>0: once the output register is free, emit the partial word. Mask = low count bits set; unused lanes are zero. Then clear count.
  - If count==0: no write.
- In FLUSH, data_ready_o=0 and guard_ready_o=0.
- Asynchronous reset mid-operation: partial data is discarded, no write is issued, and the block returns to IDLE.

Optional Feature:
- Macro: FM_WB_ZERO_CNT_EN.
- Defined:
  - Adds output zero_cnt_o [15:0], counting accepted pixels equal to 0x00 (sparsity statistic for the diff mode).
  - Cleared on start_i acceptance; saturates at 0xFFFF; holds its value after DONE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic pack: start, base 0x010, 16 pixels 0x01..0x10, ready tied 1 -> writes at 0x010 data 0x0807060504030201 and at 0x011 data 0x100F0E0D0C0B0A09, mask 0xFF each; done_o 1 cycle after the final write handshake.
- Partial flush: 3 pixels 0xAA,0xBB,0xCC then finish -> one write, data 0x0000000000CCBBAA, mask 0x07; 5 guards -> one full guard write (mask 0xF) then one with mask 0x1.
- Backpressure: mem_wr_ready_i held 0 for 10 cycles with the first word pending -> data_ready_o drops on lane 7 and the stalled word's data/addr/mask stay stable; on release, no data loss and addresses are consecutive.
- Wrap: base 0x3FF, 16 pixels -> write addresses 0x3FF then 0x000.
- Simultaneous last byte and finish: 8th pixel accepted in the same cycle as finish -> one full write (mask 0xFF) and no extra empty write; finish seen in IDLE causes no state change.
- Reset mid-PACK after 5 pixels -> all outputs 0, no write, IDLE; a subsequent start behaves normally.
